// File: rtl/alu_seq_if.sv
// ---------------------------------------------------------------------------
// alu_seq_if
//   Bundles the request/response handshake and the shared-bus ALU control
//   signals used by alu_sequencer.
//
//   slave  : sequencer side (consumes requests, drives responses and the ALU)
//   master : environment side (issues requests, accepts responses, models ALU)
//
//   Signals:
//     req_valid/req_ready/req_op/req_a/req_b   request channel
//     req_chain                                 only with ALU_SEQ_CHAIN_EN
//     rsp_valid/rsp_ready/rsp_result/rsp_err    response channel
//     alu_num/alu_enin1/alu_enin2/alu_opcode/alu_out_en/alu_result  ALU bus
// ---------------------------------------------------------------------------
interface alu_seq_if #(
  parameter int WIDTH = 16
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
`ifdef ALU_SEQ_CHAIN_EN
  logic             req_chain;
`endif
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_err;
  logic [WIDTH-1:0] alu_num;
  logic             alu_enin1;
  logic             alu_enin2;
  logic [2:0]       alu_opcode;
  logic             alu_out_en;
  logic [WIDTH-1:0] alu_result;

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready, alu_result,
`ifdef ALU_SEQ_CHAIN_EN
    input  req_chain,
`endif
    output req_ready, rsp_valid, rsp_result, rsp_err,
           alu_num, alu_enin1, alu_enin2, alu_opcode, alu_out_en
  );

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready, alu_result,
`ifdef ALU_SEQ_CHAIN_EN
    output req_chain,
`endif
    input  req_ready, rsp_valid, rsp_result, rsp_err,
           alu_num, alu_enin1, alu_enin2, alu_opcode, alu_out_en
  );
endinterface

// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
//   Runs one complete operation on a shared-bus ALU per accepted request:
//   load operand A, load operand B, hold output enable for EXEC_WAIT cycles,
//   capture the result, then present it on a valid/ready response channel.
//   Reserved opcode 7 is answered immediately with rsp_err=1, result 0,
//   without touching the ALU.
//
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous active-high reset
//     bus  alu_seq_if.slave (request, response and ALU control signals)
//
//   Parameters:
//     WIDTH      operand / result width
//     EXEC_WAIT  cycles (1..15) alu_out_en is held before capture begins
//
//   Optional feature (macro ALU_SEQ_CHAIN_EN): adds bus.req_chain; when set at
//   accept, operand A is the last successfully captured result (0 after reset).
//
//   Every output is a flop; each flop's next value is prepared in the single
//   combinational process together with the next state.
// ---------------------------------------------------------------------------
module alu_sequencer #(
  parameter int WIDTH     = 16,
  parameter int EXEC_WAIT = 1
) (
  input logic      clk,
  input logic      rst,
  alu_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_EXEC, S_CAPTURE, S_RESP
  } state_e;

  localparam logic [2:0] OP_RESERVED = 3'd7;
  localparam logic [3:0] CNT_LAST    = 4'(EXEC_WAIT - 1);

  state_e           state_q,      state_d;
  logic [3:0]       cnt_q,        cnt_d;
  logic [2:0]       op_q,         op_d;
  logic [WIDTH-1:0] b_q,          b_d;
  logic             req_ready_q,  req_ready_d;
  logic             rsp_valid_q,  rsp_valid_d;
  logic             rsp_err_q,    rsp_err_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic [WIDTH-1:0] alu_num_q,    alu_num_d;
  logic             alu_enin1_q,  alu_enin1_d;
  logic             alu_enin2_q,  alu_enin2_d;
  logic [2:0]       alu_opcode_q, alu_opcode_d;
  logic             alu_out_en_q, alu_out_en_d;
  logic [WIDTH-1:0] oper_a;

`ifdef ALU_SEQ_CHAIN_EN
  logic [WIDTH-1:0] chain_q, chain_d;
  assign oper_a = bus.req_chain ? chain_q : bus.req_a;
`else
  assign oper_a = bus.req_a;
`endif

  // NOTE: every variable gets its hold value first so no path leaves it
  // unassigned; that is what keeps this process free of inferred latches.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    b_d          = b_q;
    req_ready_d  = req_ready_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_err_d    = rsp_err_q;
    rsp_result_d = rsp_result_q;
    alu_num_d    = alu_num_q;
    alu_enin1_d  = alu_enin1_q;
    alu_enin2_d  = alu_enin2_q;
    alu_opcode_d = alu_opcode_q;
    alu_out_en_d = alu_out_en_q;
`ifdef ALU_SEQ_CHAIN_EN
    chain_d      = chain_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        // req_ready is high exactly in IDLE, so req_valid alone means accept.
        if (bus.req_valid) begin
          op_d        = bus.req_op;
          b_d         = bus.req_b;
          req_ready_d = 1'b0;
          if (bus.req_op == OP_RESERVED) begin
            state_d      = S_RESP;
            rsp_valid_d  = 1'b1;
            rsp_err_d    = 1'b1;
            rsp_result_d = '0;
          end else begin
            state_d     = S_LOAD_A;
            alu_num_d   = oper_a;
            alu_enin1_d = 1'b1;
          end
        end
      end
      S_LOAD_A: begin
        state_d     = S_LOAD_B;
        alu_num_d   = b_q;
        alu_enin1_d = 1'b0;
        alu_enin2_d = 1'b1;
      end
      S_LOAD_B: begin
        state_d      = S_EXEC;
        alu_num_d    = '0;
        alu_enin2_d  = 1'b0;
        alu_opcode_d = op_q;
        alu_out_en_d = 1'b1;
        cnt_d        = '0;
      end
      S_EXEC: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_CAPTURE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_CAPTURE: begin
        // Result is sampled on this exit edge while alu_out_en is still high.
        state_d      = S_RESP;
        rsp_result_d = bus.alu_result;
        rsp_err_d    = 1'b0;
        rsp_valid_d  = 1'b1;
        alu_out_en_d = 1'b0;
`ifdef ALU_SEQ_CHAIN_EN
        chain_d      = bus.alu_result;
`endif
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      op_q         <= '0;
      b_q          <= '0;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_result_q <= '0;
      alu_num_q    <= '0;
      alu_enin1_q  <= 1'b0;
      alu_enin2_q  <= 1'b0;
      alu_opcode_q <= '0;
      alu_out_en_q <= 1'b0;
`ifdef ALU_SEQ_CHAIN_EN
      chain_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      b_q          <= b_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_err_q    <= rsp_err_d;
      rsp_result_q <= rsp_result_d;
      alu_num_q    <= alu_num_d;
      alu_enin1_q  <= alu_enin1_d;
      alu_enin2_q  <= alu_enin2_d;
      alu_opcode_q <= alu_opcode_d;
      alu_out_en_q <= alu_out_en_d;
`ifdef ALU_SEQ_CHAIN_EN
      chain_q      <= chain_d;
`endif
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.alu_num    = alu_num_q;
  assign bus.alu_enin1  = alu_enin1_q;
  assign bus.alu_enin2  = alu_enin2_q;
  assign bus.alu_opcode = alu_opcode_q;
  assign bus.alu_out_en = alu_out_en_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_sequencer
//   Self-checking bench for alu_sequencer (WIDTH=16, EXEC_WAIT=1) with a small
//   behavioural shared-bus ALU and a queue of expected responses.
// ---------------------------------------------------------------------------
module tb_alu_sequencer;

  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] result;
    logic         err;
  } exp_t;

  logic clk;
  logic rst;
  alu_seq_if #(.WIDTH(W)) bus ();

  alu_sequencer #(.WIDTH(W), .EXEC_WAIT(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  int   viol  = 0;
  int   act   = 0;
  exp_t exp_q[$];

  function automatic logic [W-1:0] alu_fn(input logic [2:0] op,
                                          input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ~a;
      3'd6:    return b - a;
      default: return '0;
    endcase
  endfunction

  // Behavioural shared-bus ALU: operand registers load from alu_num.
  logic [W-1:0] in1, in2;
  always @(posedge clk) begin
    if (bus.alu_enin1) in1 <= bus.alu_num;
    if (bus.alu_enin2) in2 <= bus.alu_num;
  end
  always_comb bus.alu_result = bus.alu_out_en ? alu_fn(bus.alu_opcode, in1, in2) : '0;

  // Enable-exclusivity monitor and ALU activity counter.
  always @(negedge clk) begin
    if (!rst) begin
      if ((bus.alu_enin1 && bus.alu_enin2) ||
          (bus.alu_out_en && (bus.alu_enin1 || bus.alu_enin2))) viol++;
      if (bus.alu_enin1 || bus.alu_enin2 || bus.alu_out_en) act++;
    end
  end

  task automatic check_rsp_now(input string name);
    exp_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: response result=%0d err=%0b with no expected entry",
               name, bus.rsp_result, bus.rsp_err);
    end else begin
      e = exp_q.pop_front();
      if ({bus.rsp_valid, bus.rsp_result, bus.rsp_err} !== {1'b1, e.result, e.err}) begin
        bad++;
        $display("FAIL %s: got valid=%0b result=%0d err=%0b, want valid=1 result=%0d err=%0b",
                 name, bus.rsp_valid, bus.rsp_result, bus.rsp_err, e.result, e.err);
      end
    end
  endtask

  // Drive one request at a negedge; it is accepted at the following posedge.
  task automatic send_req(input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic chain);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
`ifdef ALU_SEQ_CHAIN_EN
    bus.req_chain = chain;
`else
    if (chain) $display("note: chain requested without ALU_SEQ_CHAIN_EN");
`endif
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string name);
    int n = 0;
    @(negedge clk);
    while (!bus.rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.rsp_valid) begin
      total++;
      bad++;
      $display("FAIL %s: rsp_valid timeout, got 0 want 1", name);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end else begin
      check_rsp_now(name);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_result, bus.alu_num,
         bus.alu_enin1, bus.alu_enin2, bus.alu_opcode, bus.alu_out_en} !==
        {1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 3'd0, 1'b0}) begin
      bad++;
      $display("FAIL reset_state: ready=%0b valid=%0b err=%0b res=%0d num=%0d en1=%0b en2=%0b opc=%0d oen=%0b, want 1 0 0 0 0 0 0 0 0",
               bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_result, bus.alu_num,
               bus.alu_enin1, bus.alu_enin2, bus.alu_opcode, bus.alu_out_en);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    exp_q.push_back('{result: alu_fn(3'd0, 16'd256, 16'd255), err: 1'b0});
    send_req(3'd0, 16'd256, 16'd255, 1'b0);
    @(negedge clk);
    total++;
    if ({bus.alu_enin1, bus.alu_enin2, bus.alu_out_en, bus.alu_num} !== {3'b100, 16'd256}) begin
      bad++;
      $display("FAIL basic_load_a: en1/en2/oen=%b%b%b num=%0d, want 100 num=256",
               bus.alu_enin1, bus.alu_enin2, bus.alu_out_en, bus.alu_num);
    end
    @(negedge clk);
    total++;
    if ({bus.alu_enin1, bus.alu_enin2, bus.alu_out_en, bus.alu_num} !== {3'b010, 16'd255}) begin
      bad++;
      $display("FAIL basic_load_b: en1/en2/oen=%b%b%b num=%0d, want 010 num=255",
               bus.alu_enin1, bus.alu_enin2, bus.alu_out_en, bus.alu_num);
    end
    @(negedge clk);
    total++;
    if ({bus.alu_enin1, bus.alu_enin2, bus.alu_out_en, bus.alu_num, bus.alu_opcode, bus.rsp_valid} !==
        {3'b001, 16'd0, 3'd0, 1'b0}) begin
      bad++;
      $display("FAIL basic_exec: en=%b%b%b num=%0d opc=%0d valid=%0b, want 001 0 0 0",
               bus.alu_enin1, bus.alu_enin2, bus.alu_out_en, bus.alu_num, bus.alu_opcode, bus.rsp_valid);
    end
    @(negedge clk);
    total++;
    if ({bus.alu_out_en, bus.rsp_valid} !== 2'b10) begin
      bad++;
      $display("FAIL basic_capture: oen=%0b valid=%0b, want oen=1 valid=0",
               bus.alu_out_en, bus.rsp_valid);
    end
    @(negedge clk);
    total++;
    if (bus.alu_out_en !== 1'b0) begin
      bad++;
      $display("FAIL basic_resp_oen: oen=%0b want 0", bus.alu_out_en);
    end
    check_rsp_now("basic_rsp_at_4");
    @(negedge clk);
    total++;
    if ({bus.req_ready, bus.rsp_valid} !== 2'b10) begin
      bad++;
      $display("FAIL basic_back_idle: ready=%0b valid=%0b, want 1 0", bus.req_ready, bus.rsp_valid);
    end
  endtask

  task automatic test_sweep();
    for (int i = 0; i < 7; i++) begin
      logic [W-1:0] a;
      a = 16'(256 + i);
      exp_q.push_back('{result: alu_fn(3'(i), a, 16'd255), err: 1'b0});
      send_req(3'(i), a, 16'd255, 1'b0);
      wait_rsp($sformatf("sweep_op%0d", i));
    end
  endtask

  task automatic test_reserved();
    int act0;
    act0 = act;
    exp_q.push_back('{result: 16'd0, err: 1'b1});
    send_req(3'd7, 16'd5, 16'd3, 1'b0);
    @(negedge clk);
    check_rsp_now("reserved_rsp");
    @(negedge clk);
    total++;
    if (act !== act0) begin
      bad++;
      $display("FAIL reserved_no_alu: alu active cycles=%0d want 0", act - act0);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] r;
    int n = 0;
    r = alu_fn(3'd2, 16'hF0F0, 16'h0FF0);
    bus.rsp_ready = 1'b0;
    exp_q.push_back('{result: r, err: 1'b0});
    send_req(3'd2, 16'hF0F0, 16'h0FF0, 1'b0);
    @(negedge clk);
    while (!bus.rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_rsp_now("bp_first");
    // Hold a second request pending while the response is stalled.
    bus.req_valid = 1'b1;
    bus.req_op    = 3'd4;
    bus.req_a     = 16'd1;
    bus.req_b     = 16'd2;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if ({bus.rsp_valid, bus.rsp_result, bus.req_ready} !== {1'b1, r, 1'b0}) begin
        bad++;
        $display("FAIL bp_hold%0d: valid=%0b result=%0d ready=%0b, want 1 %0d 0",
                 i, bus.rsp_valid, bus.rsp_result, bus.req_ready, r);
      end
    end
    bus.rsp_ready = 1'b1;
    exp_q.push_back('{result: alu_fn(3'd4, 16'd1, 16'd2), err: 1'b0});
    @(negedge clk);
    total++;
    if ({bus.req_ready, bus.rsp_valid} !== 2'b10) begin
      bad++;
      $display("FAIL bp_release: ready=%0b valid=%0b, want 1 0", bus.req_ready, bus.rsp_valid);
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    wait_rsp("bp_second");
  endtask

  task automatic test_reset_mid();
    int n = 0;
    send_req(3'd1, 16'd700, 16'd55, 1'b0);
    @(negedge clk);
    while (!bus.alu_out_en && n < 20) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({bus.alu_out_en, bus.alu_enin1, bus.alu_enin2, bus.rsp_valid, bus.req_ready, bus.alu_num} !==
        {5'b00001, 16'd0}) begin
      bad++;
      $display("FAIL rst_mid: oen=%0b en1=%0b en2=%0b valid=%0b ready=%0b num=%0d, want 0 0 0 0 1 0",
               bus.alu_out_en, bus.alu_enin1, bus.alu_enin2, bus.rsp_valid, bus.req_ready, bus.alu_num);
    end
    exp_q.push_back('{result: alu_fn(3'd3, 16'h1200, 16'h0034), err: 1'b0});
    send_req(3'd3, 16'h1200, 16'h0034, 1'b0);
    wait_rsp("rst_mid_after");
  endtask

`ifdef ALU_SEQ_CHAIN_EN
  task automatic test_chain();
    exp_q.push_back('{result: 16'd30, err: 1'b0});
    send_req(3'd0, 16'd10, 16'd20, 1'b0);
    wait_rsp("chain_first");
    exp_q.push_back('{result: 16'd35, err: 1'b0});
    send_req(3'd0, 16'd999, 16'd5, 1'b1);
    @(negedge clk);
    total++;
    if ({bus.alu_enin1, bus.alu_num} !== {1'b1, 16'd30}) begin
      bad++;
      $display("FAIL chain_load_a: en1=%0b num=%0d, want 1 30", bus.alu_enin1, bus.alu_num);
    end
    bus.req_chain = 1'b0;
    wait_rsp("chain_second");
  endtask
`endif

  initial begin
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
`ifdef ALU_SEQ_CHAIN_EN
    bus.req_chain = 1'b0;
`endif
    test_reset();
    test_basic();
    test_sweep();
    test_reserved();
    test_backpressure();
    test_reset_mid();
`ifdef ALU_SEQ_CHAIN_EN
    test_chain();
`endif
    repeat (2) @(negedge clk);
    total++;
    if (viol !== 0) begin
      bad++;
      $display("FAIL enable_exclusive: violations=%0d want 0", viol);
    end
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL scoreboard_drain: leftover=%0d want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Controller that runs one complete ALU operation per accepted request on the shared-bus ALU.
- Sequences the ALU operand loads, opcode, output enable and result capture, so upstream logic sees only a valid/ready request/response interface.
- Sits between the instruction-decode stage and the ALU instance; it is the only driver of the ALU's operand bus and enables.

Parameters:
- WIDTH, 16, data width of operands, ALU bus and result.
- EXEC_WAIT, 1, cycles (1..15) that the output enable is held before the result is sampled.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_op  in  3  ALU opcode; 0..6 valid, 7 reserved
- req_a  in  WIDTH  operand 1
- req_b  in  WIDTH  operand 2
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  WIDTH  captured ALU result
- rsp_err  out  1  request rejected (reserved opcode)
- alu_num  out  WIDTH  ALU shared operand bus
- alu_enin1  out  1  ALU operand-1 load enable
- alu_enin2  out  1  ALU operand-2 load enable
- alu_opcode  out  3  ALU opcode
- alu_out_en  out  1  ALU result output enable
- alu_result  in  WIDTH  ALU result bus

Behaviour:
- One clock; reset is synchronous and active-high. All outputs are registered.
- Reset values:
  - State IDLE; req_ready=1; rsp_valid=0; rsp_err=0; rsp_result=0.
  - alu_num=0, alu_enin1=0, alu_enin2=0, alu_opcode=0, alu_out_en=0.
  - Wait counter=0.
- Request capture: a request is accepted on a clock edge where req_valid&&req_ready. At that edge req_op, req_a and req_b are latched internally. req_ready=1 only in IDLE.
- States and transitions:
  - IDLE: on accept with req_op!=7, go to LOAD_A. On accept with req_op==7, go to RESP with rsp_err=1 and rsp_result=0; no ALU signal toggles.
  - LOAD_A (1 cycle): alu_num=A, alu_enin1=1. Next state is LOAD_B.
  - LOAD_B (1 cycle): alu_num=B, alu_enin1=0, alu_enin2=1. Next state is EXEC.
  - EXEC (EXEC_WAIT cycles): alu_enin2=0, alu_opcode=op, alu_out_en=1. The counter counts EXEC_WAIT cycles.
  - After EXEC_WAIT, go to CAPTURE.
  - CAPTURE (1 cycle): rsp_result<=alu_result, sampled at the exit edge while alu_out_en is still 1. Next state is RESP.
  - RESP: alu_out_en=0 and rsp_valid=1. rsp_result and rsp_err are held stable until rsp_valid&&rsp_ready, then go to IDLE and clear rsp_valid/rsp_err.
- Enable rules:
  - alu_enin1 and alu_enin2 are never high in the same cycle.
  - alu_out_en is never high while either load enable is high.
- Latency: with EXEC_WAIT=1 and rsp_ready held high, rsp_valid rises 4 cycles after the accept edge. The next request can be accepted at the edge following the response handshake; there is no back-to-back overlap.
- alu_opcode holds its last value outside EXEC/CAPTURE.
- alu_num is 0 outside the LOAD states.
- Backpressure: with rsp_ready=0 the sequencer stays in RESP indefinitely and req_ready stays 0.
- Reset mid-operation: any state returns to IDLE at the reset edge, all enables drop in the same cycle, and any pending response is discarded.
- Width: rsp_result is the full WIDTH bits of alu_result, with no extension or truncation.

Optional Feature:
- Macro: ALU_SEQ_CHAIN_EN
- Defined:
  - Adds input port req_chain (1 bit).
  - If req_chain=1 at accept, operand A is replaced by the most recent successfully captured rsp_result.
  - That value is 0 after reset; err responses do not update it.
  - req_a is ignored in that case. Sequencing is otherwise identical.
- Not defined: no req_chain port; operand A is always req_a.

Test Plan:
- Reset, then request op=0, A=256, B=255, EXEC_WAIT=1, rsp_ready=1:
  - enin1 pulses with num=256, then enin2 pulses with num=255.
  - out_en is high for 2 cycles.
  - rsp_valid rises 4 cycles after accept.
  - rsp_result equals the alu_result driven by the bench model.
- Sweep op 0..6 with A incrementing 256..262 and B=255: each response carries the matching result; the enable-exclusivity assertions hold throughout.
- req_op=7, A=5, B=3: the next cycle gives rsp_valid=1, rsp_err=1, rsp_result=0, and no alu_enin1/alu_enin2/alu_out_en activity.
- rsp_ready=0 for 10 cycles after the response:
  - rsp_valid and rsp_result stay stable and req_ready stays 0.
  - A new req_valid is not accepted until the handshake completes.
- Assert rst during EXEC:
  - The next cycle shows state IDLE, alu_out_en=0, rsp_valid=0 and req_ready=1.
  - A subsequent request completes normally.
- ALU_SEQ_CHAIN_EN:
  - Request op=0, A=10, B=20 returns R.
  - A chained request with req_a=999 then drives alu_num=R during LOAD_A.
